// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and constants for the instruction memory arbiter
package instr_mem_pkg;

    typedef enum logic {
        PORT_AXI  = 1'b0,
        PORT_CORE = 1'b1
    } port_e;

    localparam int WORD_LSB = 2;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter remembering the last winner
module rr_arb2
    import instr_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    port_e last_q;

    // On conflict the port that did not win last time is granted; a lone requester wins outright
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = (last_q == PORT_CORE) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    // Winner history only moves on cycles that actually issue a grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_CORE;
        end else if (adv_i) begin
            last_q <= gnt_o[1] ? PORT_CORE : PORT_AXI;
        end
    end

endmodule

// File: rtl/instr_mem_arbiter.sv
// rtl/instr_mem_arbiter.sv - merges AXI and core fetch ports onto one RAM/ROM access port
module instr_mem_arbiter
    import instr_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    axi_req_i,
    input  logic                    axi_we_i,
    input  logic [DATA_WIDTH/8-1:0] axi_be_i,
    input  logic [31:0]             axi_addr_i,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    output logic                    axi_gnt_o,
    output logic                    axi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,
    input  logic                    core_req_i,
    input  logic [31:0]             core_addr_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       rvalid_q;
    port_e      owner_q;

    // Byte-offset and above-window address bits never reach the RAM
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_addr_i[31:ADDR_WIDTH+2], axi_addr_i[WORD_LSB-1:0],
                                core_addr_i[31:ADDR_WIDTH+2], core_addr_i[WORD_LSB-1:0]};

    assign req     = {core_req_i, axi_req_i};
    assign any_gnt = |gnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .adv_i (any_gnt),
        .gnt_o (gnt)
    );

    assign axi_gnt_o  = gnt[0];
    assign core_gnt_o = gnt[1];

    // Request mux: winner's access goes out, fetches are full-word reads, idle drives zeros
    always_comb begin
        ram_en_o    = any_gnt;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (gnt[0]) begin
            ram_addr_o  = axi_addr_i[ADDR_WIDTH+1:WORD_LSB];
            ram_we_o    = axi_we_i;
            ram_be_o    = axi_be_i;
            ram_wdata_o = axi_wdata_i;
        end else if (gnt[1]) begin
            ram_addr_o  = core_addr_i[ADDR_WIDTH+1:WORD_LSB];
            ram_be_o    = '1;
        end
    end

    // Remember who was granted so the RAM's one-cycle-late data goes back to that port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            owner_q  <= PORT_CORE;
        end else begin
            rvalid_q <= any_gnt;
            if (any_gnt) begin
                owner_q <= gnt[1] ? PORT_CORE : PORT_AXI;
            end
        end
    end

    assign axi_rvalid_o  = rvalid_q && (owner_q == PORT_AXI);
    assign core_rvalid_o = rvalid_q && (owner_q == PORT_CORE);
    assign axi_rdata_o   = axi_rvalid_o  ? ram_rdata_i : '0;
    assign core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;

endmodule
